// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller that shares the display
// between two 32-bit sources, snapshotting the chosen value once per frame.
module sseg_scan_ctrl #(
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 500,
   parameter int ROT_FRAMES = 256
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_src0_data,
   input  logic        i_src0_valid,
   input  logic [31:0] i_src1_data,
   input  logic        i_src1_valid,
   input  logic [1:0]  i_mode,
   input  logic        i_blank_lz,
   output logic [7:0]  o_an,
   output logic [6:0]  o_seg,
   output logic        o_dp,
   output logic        o_cur_src,
   output logic        o_frame
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int FW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
   localparam logic [FW-1:0] ROT_LAST   = FW'(ROT_FRAMES - 1);

   localparam logic [1:0] MODE_SRC0  = 2'b00;
   localparam logic [1:0] MODE_SRC1  = 2'b01;
   localparam logic [1:0] MODE_ROT   = 2'b10;
   localparam logic [1:0] MODE_SPLIT = 2'b11;

   logic [PW-1:0] presc;
   logic [2:0]    idx;
   logic [FW-1:0] frame_cnt;
   logic [31:0]   snap;
   logic          cur_src;
   logic [1:0]    mode_q;

   logic          tick;
   logic          boundary;
   logic [FW-1:0] nxt_cnt;
   logic          nxt_src;
   logic          split;
   logic [2:0]    top;
   logic          all_zero;
   logic          lz_blank;
   logic [3:0]    nib;
   logic          blanking;
   logic          dp_on;
   logic [6:0]    seg_dec;

   assign tick      = (presc == PRESC_LAST);
   assign boundary  = tick && (idx == 3'd7);
   assign blanking  = (presc < BLANK_END);
   assign o_cur_src = cur_src;

   // Rotation bookkeeping is decided from the mode being latched on this boundary.
   always_comb begin
      nxt_cnt = '0;
      nxt_src = 1'b0;
      case (i_mode)
         MODE_ROT: begin
            if (frame_cnt == ROT_LAST) begin
               nxt_cnt = '0;
               nxt_src = ~cur_src;
            end else begin
               nxt_cnt = frame_cnt + FW'(1);
               nxt_src = cur_src;
            end
         end
         MODE_SRC1: nxt_src = 1'b1;
         default:   nxt_src = 1'b0;
      endcase
   end

   // Leading-zero test covers nibbles idx..top, where top is the end of the current half in split mode.
   always_comb begin
      split    = (mode_q == MODE_SPLIT);
      top      = (split && !idx[2]) ? 3'd3 : 3'd7;
      all_zero = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if ((3'(k) >= idx) && (3'(k) <= top) && (snap[4*k +: 4] != 4'h0)) begin
            all_zero = 1'b0;
         end
      end
      lz_blank = i_blank_lz && all_zero && (idx != 3'd0) && !(split && (idx == 3'd4));
      nib      = snap[{idx, 2'b00} +: 4];
      dp_on    = !blanking &&
                 (((idx == 3'd0) && cur_src && ((mode_q == MODE_SRC1) || (mode_q == MODE_ROT))) ||
                  (split && (idx == 3'd4)));
   end

   always_comb begin
      seg_dec = 7'h7F;
      case (nib)
         4'h0: seg_dec = 7'b0000001;
         4'h1: seg_dec = 7'b1001111;
         4'h2: seg_dec = 7'b0010010;
         4'h3: seg_dec = 7'b0000110;
         4'h4: seg_dec = 7'b1001100;
         4'h5: seg_dec = 7'b0100100;
         4'h6: seg_dec = 7'b0100000;
         4'h7: seg_dec = 7'b0001111;
         4'h8: seg_dec = 7'b0000000;
         4'h9: seg_dec = 7'b0000100;
         4'hA: seg_dec = 7'b0001000;
         4'hB: seg_dec = 7'b1100000;
         4'hC: seg_dec = 7'b0110001;
         4'hD: seg_dec = 7'b1000010;
         4'hE: seg_dec = 7'b0110000;
         4'hF: seg_dec = 7'b0111000;
         default: seg_dec = 7'h7F;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         presc     <= '0;
         idx       <= 3'd0;
         frame_cnt <= '0;
         snap      <= 32'h0;
         cur_src   <= 1'b0;
         mode_q    <= MODE_SRC0;
         o_an      <= 8'hFF;
         o_seg     <= 7'h7F;
         o_dp      <= 1'b1;
         o_frame   <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            idx <= idx + 3'd1;
         end
         // Mode, rotation state and snapshot all move together so a frame never mixes sources.
         if (boundary) begin
            mode_q    <= i_mode;
            frame_cnt <= nxt_cnt;
            cur_src   <= nxt_src;
            if (i_mode == MODE_SPLIT) begin
               if (i_src0_valid) snap[15:0]  <= i_src0_data[15:0];
               if (i_src1_valid) snap[31:16] <= i_src1_data[15:0];
            end else if (nxt_src) begin
               if (i_src1_valid) snap <= i_src1_data;
            end else begin
               if (i_src0_valid) snap <= i_src0_data;
            end
         end
         o_an    <= blanking ? 8'hFF : ~(8'b1 << idx);
         o_seg   <= lz_blank ? 7'h7F : seg_dec;
         o_dp    <= ~dp_on;
         o_frame <= boundary;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: an arithmetic model of the scan timeline is
// compared every cycle, and literal digit expectations pin the model.
module tb_sseg_scan_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int BLANK_CYC  = 1;
   localparam int ROT_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src0_data, src1_data;
   logic        src0_valid, src1_valid;
   logic [1:0]  mode;
   logic        blank_lz;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp, o_cur_src, o_frame;

   int n_cmp = 0;
   int n_err = 0;

   sseg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .ROT_FRAMES(ROT_FRAMES)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_src0_data(src0_data), .i_src0_valid(src0_valid),
      .i_src1_data(src1_data), .i_src1_valid(src1_valid),
      .i_mode(mode), .i_blank_lz(blank_lz),
      .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_cur_src(o_cur_src), .o_frame(o_frame)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   int          t, p, d, m_src, m_cnt, m_mode;
   logic [31:0] m_snap, rest;
   logic [7:0]  one8 = 8'd1;
   logic        m_split, lz, model_ok = 1'b0;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_cur, e_frame;

   always @(posedge clk) begin
      if (rst) begin
         t = 0; m_snap = 0; m_src = 0; m_cnt = 0; m_mode = 0;
         e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
         model_ok = 1'b1;
      end else begin
         p = t % CLK_DIV;
         d = (t / CLK_DIV) % 8;
         m_split = (m_mode == 3);
         if (m_split) rest = (d < 4) ? 32'(m_snap[15:0] >> (4 * d)) : 32'(m_snap[31:16] >> (4 * (d - 4)));
         else         rest = m_snap >> (4 * d);
         lz = blank_lz && (d != 0) && !(m_split && d == 4) && (rest == 0);
         e_an  = (p < BLANK_CYC) ? 8'hFF : ~(one8 << d);
         e_seg = lz ? 7'h7F : seg_tab[(m_snap >> (4 * d)) & 32'hF];
         e_dp  = !((p >= BLANK_CYC) &&
                   ((d == 0 && m_src == 1 && (m_mode == 1 || m_mode == 2)) || (d == 4 && m_split)));
         e_frame = (p == CLK_DIV - 1) && (d == 7);
         if (e_frame) begin
            m_mode = int'(mode);
            if (m_mode == 2) begin
               m_cnt = (m_cnt + 1) % ROT_FRAMES;
               if (m_cnt == 0) m_src = 1 - m_src;
            end else begin
               m_cnt = 0;
               m_src = (m_mode == 1) ? 1 : 0;
            end
            if (m_mode == 3) begin
               if (src0_valid) m_snap[15:0]  = src0_data[15:0];
               if (src1_valid) m_snap[31:16] = src1_data[15:0];
            end else if (m_src == 1) begin
               if (src1_valid) m_snap = src1_data;
            end else if (src0_valid) begin
               m_snap = src0_data;
            end
         end
         t++;
      end
      e_cur = (m_src == 1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         check("an",      32'(o_an),      32'(e_an));
         check("seg",     32'(o_seg),     32'(e_seg));
         check("dp",      32'(o_dp),      32'(e_dp));
         check("cur_src", 32'(o_cur_src), 32'(e_cur));
         check("frame",   32'(o_frame),   32'(e_frame));
      end
   end

   // ---------------- drivers ----------------
   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting, got no event, expected one", name);
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_frame !== 1'b1 && n < 100);
      if (n >= 100) timeout("wait_frame");
   endtask

   task automatic wait_digit(input int k);
      logic [7:0] tgt;
      int n = 0;
      tgt = ~(one8 << k);
      do begin
         @(negedge clk);
         n++;
      end while (o_an !== tgt && n < 100);
      if (n >= 100) timeout("wait_digit");
   endtask

   // dpx < 0 skips the decimal-point check.
   task automatic dig(input string name, input int k, input logic [6:0] seg, input int dpx);
      wait_digit(k);
      check(name, 32'(o_seg), 32'(seg));
      if (dpx >= 0) check({name, "_dp"}, 32'(o_dp), 32'(dpx));
   endtask

   logic [7:0] an_seq [8] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD};

   initial begin
      rst = 1'b1; mode = 2'b00; blank_lz = 1'b0;
      src0_data = 32'h12345678; src0_valid = 1'b1;
      src1_data = 32'h0;        src1_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_an",  32'(o_an),  32'hFF);
      check("rst_seg", 32'(o_seg), 32'h7F);
      check("rst_dp",  32'(o_dp),  32'h1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("an_seq", 32'(o_an), 32'(an_seq[i]));
      end

      // mode 00 snapshot; a mid-frame change stays hidden until the next boundary
      wait_frame();
      src0_data = 32'hAAAAAAAA;
      dig("m0_d0", 0, 7'b0000000, -1);
      dig("m0_d7", 7, 7'b1001111, -1);
      wait_frame();
      dig("m0_new_d0", 0, 7'b0001000, 1);

      // leading-zero blanking
      src0_data = 32'h000000A5; blank_lz = 1'b1;
      wait_frame();
      dig("lz_d0", 0, 7'b0100100, -1);
      dig("lz_d1", 1, 7'b0001000, -1);
      dig("lz_d2", 2, 7'h7F, -1);
      dig("lz_d7", 7, 7'h7F, -1);
      src0_data = 32'h0;
      wait_frame();
      dig("zero_d0", 0, 7'b0000001, -1);
      dig("zero_d1", 1, 7'h7F, -1);

      // auto-rotate
      mode = 2'b10; blank_lz = 1'b0;
      src0_data = 32'h11111111; src1_data = 32'h22222222;
      wait_frame();
      check("rot_b1_src", 32'(o_cur_src), 32'h0);
      dig("rot_b1_d0", 0, 7'b1001111, 1);
      wait_frame();
      check("rot_b2_src", 32'(o_cur_src), 32'h1);
      dig("rot_b2_d0", 0, 7'b0010010, 0);
      dig("rot_b2_d3", 3, 7'b0010010, 1);
      wait_frame();
      check("rot_b3_src", 32'(o_cur_src), 32'h1);
      wait_frame();
      check("rot_b4_src", 32'(o_cur_src), 32'h0);
      dig("rot_b4_d0", 0, 7'b1001111, 1);
      wait_frame();
      wait_frame();
      check("rot_b6_src", 32'(o_cur_src), 32'h1);

      // reset mid-frame at digit 5
      wait_digit(5);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_an",    32'(o_an),      32'hFF);
      check("mrst_seg",   32'(o_seg),     32'h7F);
      check("mrst_src",   32'(o_cur_src), 32'h0);
      check("mrst_frame", 32'(o_frame),   32'h0);
      rst = 1'b0; blank_lz = 1'b1;
      mode = 2'b11; src0_data = 32'hFFFF0003; src1_data = 32'h0000BEEF; src1_valid = 1'b0;
      dig("cleared_d0", 0, 7'b0000001, 1);
      dig("cleared_d1", 1, 7'h7F, -1);

      // split mode with src1 held
      wait_frame();
      dig("split_d0", 0, 7'b0000110, 1);
      dig("split_d1", 1, 7'h7F, -1);
      dig("split_d3", 3, 7'h7F, -1);
      dig("split_d4", 4, 7'b0000001, 0);
      dig("split_d5", 5, 7'h7F, -1);
      check("split_src", 32'(o_cur_src), 32'h0);
      src1_valid = 1'b1;
      wait_frame();
      dig("split2_d4", 4, 7'b0111000, 0);
      dig("split2_d5", 5, 7'b0110000, -1);
      dig("split2_d7", 7, 7'b1100000, -1);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
